// File: rtl/seg_pkg.sv
// Shared types and constants for the seven-segment scan path.
// SEG_ZERO / SEG_BLANK match the upstream BCD-to-segment decoder encoding.
package seg_pkg;

  localparam int unsigned SEG_W = 8;
  localparam int unsigned DIG_W = 2;

  typedef logic [SEG_W-1:0] seg_t;
  typedef logic [DIG_W-1:0] dig_t;

  // Both digit patterns captured together once per frame.
  typedef struct packed {
    seg_t tens;
    seg_t units;
  } seg_pair_t;

  // Phase within a digit slot.
  typedef enum logic {
    PH_BLANK = 1'b0,
    PH_SHOW  = 1'b1
  } phase_e;

  localparam seg_t SEG_ZERO  = 8'h3F;
  localparam seg_t SEG_BLANK = 8'h00;

  // Active-low digit enables: bit 1 = tens, bit 0 = units.
  localparam dig_t DIG_NONE  = 2'b11;
  localparam dig_t DIG_TENS  = 2'b01;
  localparam dig_t DIG_UNITS = 2'b10;

  // True when a tens pattern should be suppressed as a leading zero.
  function automatic logic is_lz(input seg_t pat, input logic lz_en);
    return lz_en && (pat == SEG_ZERO);
  endfunction

endpackage

// File: rtl/seg_scan_mux_if.sv
// Bus between the segment decoder, the scan driver and the display pins.
//   seg_in_1 / seg_in_2 : tens / units patterns from the decoder
//   seg_out             : shared segment bus
//   dig_sel             : active-low digit enables
//   frame_start         : one-cycle pulse on each input latch
interface seg_scan_mux_if;
  import seg_pkg::*;

  seg_t seg_in_1;
  seg_t seg_in_2;
  seg_t seg_out;
  dig_t dig_sel;
  logic frame_start;

  // Decoder / environment side.
  modport master (
    output seg_in_1,
    output seg_in_2,
    input  seg_out,
    input  dig_sel,
    input  frame_start
  );

  // Scan driver side.
  modport slave (
    input  seg_in_1,
    input  seg_in_2,
    output seg_out,
    output dig_sel,
    output frame_start
  );

endinterface

// File: rtl/scan_tick_counter.sv
// Slot timebase: counts 0..SCAN_DIV-1 and toggles the slot index on wrap.
//   clk, rst : clock and synchronous active-high reset
//   cnt_q    : position within the current slot
//   slot_q   : 0 = tens slot, 1 = units slot
//   wrap_c   : combinational, high on the last cycle of a slot
module scan_tick_counter #(
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic                        clk,
  input  logic                        rst,
  output logic [$clog2(SCAN_DIV)-1:0] cnt_q,
  output logic                        slot_q,
  output logic                        wrap_c
);

  localparam int unsigned CNT_W = $clog2(SCAN_DIV);

  logic [CNT_W-1:0] cnt_d;
  logic             slot_d;

  // Next count and slot.
  always_comb begin
    wrap_c = (cnt_q == CNT_W'(SCAN_DIV - 1));
    cnt_d  = cnt_q + CNT_W'(1);
    slot_d = slot_q;
    if (wrap_c) begin
      cnt_d  = '0;
      slot_d = ~slot_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      slot_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      slot_q <= slot_d;
    end
  end

endmodule

// File: rtl/seg_scan_mux.sv
// Two-digit seven-segment scan driver. Latches both decoder patterns once
// per frame, then alternates tens/units slots on one shared segment bus,
// each slot opening with a blanking gap to suppress ghosting.
//   clk, rst : clock and synchronous active-high reset
//   bus      : seg_in_1/seg_in_2 in; seg_out, dig_sel, frame_start out
module seg_scan_mux
  import seg_pkg::*;
#(
  parameter int unsigned SCAN_DIV     = 50000,
  parameter int unsigned BLANK_CYCLES = 16,
  parameter bit          LZ_BLANK     = 1'b1
) (
  input  logic           clk,
  input  logic           rst,
  seg_scan_mux_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(SCAN_DIV);

  // Reject parameter sets that leave no visible time or no blanking gap.
  if (SCAN_DIV < 4) begin : g_bad_div
    $error("seg_scan_mux: SCAN_DIV must be >= 4");
  end
  if ((BLANK_CYCLES < 1) || (BLANK_CYCLES >= SCAN_DIV)) begin : g_bad_blank
    $error("seg_scan_mux: BLANK_CYCLES must be in [1, SCAN_DIV)");
  end

  logic [CNT_W-1:0] cnt;
  logic             slot;
  logic             wrap_c;
  logic             latch_c;
  phase_e           phase_c;

  seg_pair_t lat_q, lat_d;
  seg_t      seg_out_q, seg_out_d;
  dig_t      dig_sel_q, dig_sel_d;
  logic      frame_start_q, frame_start_d;

  scan_tick_counter #(
    .SCAN_DIV (SCAN_DIV)
  ) u_tick (
    .clk    (clk),
    .rst    (rst),
    .cnt_q  (cnt),
    .slot_q (slot),
    .wrap_c (wrap_c)
  );

  // Latch on entry to the tens slot; decode phase and next bus values.
  always_comb begin
    latch_c       = wrap_c & slot;
    phase_c       = (cnt < CNT_W'(BLANK_CYCLES)) ? PH_BLANK : PH_SHOW;
    lat_d         = lat_q;
    seg_out_d     = SEG_BLANK;
    dig_sel_d     = DIG_NONE;
    frame_start_d = latch_c;

    if (latch_c) begin
      lat_d.tens  = bus.seg_in_1;
      lat_d.units = bus.seg_in_2;
    end

    // Suppressed leading zero keeps the tens slot fully dark.
    if (phase_c == PH_SHOW) begin
      if (!slot) begin
        if (!is_lz(lat_q.tens, LZ_BLANK)) begin
          seg_out_d = lat_q.tens;
          dig_sel_d = DIG_TENS;
        end
      end else begin
        seg_out_d = lat_q.units;
        dig_sel_d = DIG_UNITS;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lat_q         <= '0;
      seg_out_q     <= SEG_BLANK;
      dig_sel_q     <= DIG_NONE;
      frame_start_q <= 1'b0;
    end else begin
      lat_q         <= lat_d;
      seg_out_q     <= seg_out_d;
      dig_sel_q     <= dig_sel_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign bus.seg_out     = seg_out_q;
  assign bus.dig_sel     = dig_sel_q;
  assign bus.frame_start = frame_start_q;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Bench for seg_scan_mux with SCAN_DIV=8, BLANK_CYCLES=2; one instance with
// leading-zero blanking and one without, driven with identical inputs.
module tb_seg_scan_mux;
  import seg_pkg::*;

  localparam int unsigned SD    = 8;
  localparam int unsigned BC    = 2;
  localparam int          FRAME = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seg_scan_mux_if bus_lz ();
  seg_scan_mux_if bus_nz ();

  seg_scan_mux #(.SCAN_DIV(SD), .BLANK_CYCLES(BC), .LZ_BLANK(1'b1)) dut_lz (
    .clk (clk), .rst (rst), .bus (bus_lz)
  );
  seg_scan_mux #(.SCAN_DIV(SD), .BLANK_CYCLES(BC), .LZ_BLANK(1'b0)) dut_nz (
    .clk (clk), .rst (rst), .bus (bus_nz)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: time since reset plus the patterns captured at frame starts.
  int          t;
  logic [7:0]  m_lat1, m_lat2;
  logic [7:0]  e_seg_lz, e_seg_nz;
  logic [1:0]  e_dig_lz, e_dig_nz;
  logic        e_fs;

  task automatic set_in(input logic [7:0] a, input logic [7:0] b);
    bus_lz.seg_in_1 = a; bus_lz.seg_in_2 = b;
    bus_nz.seg_in_1 = a; bus_nz.seg_in_2 = b;
  endtask

  // Advance one clock and update the expected outputs from the display rules.
  task automatic tick();
    logic       r;
    logic [7:0] a, b;
    int         c, s;
    r = rst; a = bus_lz.seg_in_1; b = bus_lz.seg_in_2;
    @(posedge clk);
    if (r) begin
      t = 0; m_lat1 = 8'h00; m_lat2 = 8'h00;
      e_seg_lz = 8'h00; e_seg_nz = 8'h00;
      e_dig_lz = 2'b11; e_dig_nz = 2'b11; e_fs = 1'b0;
    end else begin
      c = t % SD;
      s = (t / SD) % 2;
      if (c < BC) begin
        e_seg_lz = 8'h00; e_dig_lz = 2'b11; e_seg_nz = 8'h00; e_dig_nz = 2'b11;
      end else if (s == 0) begin
        e_seg_nz = m_lat1; e_dig_nz = 2'b01;
        if (m_lat1 == 8'h3F) begin e_seg_lz = 8'h00; e_dig_lz = 2'b11; end
        else begin e_seg_lz = m_lat1; e_dig_lz = 2'b01; end
      end else begin
        e_seg_lz = m_lat2; e_dig_lz = 2'b10; e_seg_nz = m_lat2; e_dig_nz = 2'b10;
      end
      t++;
      e_fs = ((t % FRAME) == 0);
      if (e_fs) begin m_lat1 = a; m_lat2 = b; end
    end
    #1;
  endtask

  task automatic test_reset();
    set_in(8'h06, 8'h5B);
    rst = 1'b1;
    tick(); tick();
    checks++;
    if ({bus_lz.seg_out, bus_lz.dig_sel, bus_lz.frame_start} !== {8'h00, 2'b11, 1'b0}) begin
      failures++;
      $display("FAIL reset_lz: got seg=%h dig=%b fs=%b want seg=00 dig=11 fs=0",
               bus_lz.seg_out, bus_lz.dig_sel, bus_lz.frame_start);
    end
    checks++;
    if ({bus_nz.seg_out, bus_nz.dig_sel, bus_nz.frame_start} !== {8'h00, 2'b11, 1'b0}) begin
      failures++;
      $display("FAIL reset_nz: got seg=%h dig=%b fs=%b want seg=00 dig=11 fs=0",
               bus_nz.seg_out, bus_nz.dig_sel, bus_nz.frame_start);
    end
    rst = 1'b0;
  endtask

  task automatic test_idle();
    int first_fs = -1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      checks++;
      if ({bus_lz.seg_out, bus_lz.dig_sel, bus_lz.frame_start} !== {e_seg_lz, e_dig_lz, e_fs}) begin
        failures++;
        $display("FAIL idle cyc=%0d: got seg=%h dig=%b fs=%b want seg=%h dig=%b fs=%b", i,
                 bus_lz.seg_out, bus_lz.dig_sel, bus_lz.frame_start, e_seg_lz, e_dig_lz, e_fs);
      end
      if (bus_lz.frame_start === 1'b1 && first_fs < 0) first_fs = i;
    end
    checks++;
    if (first_fs !== 16) begin
      failures++;
      $display("FAIL first_frame_start: got cycle %0d want 16", first_fs);
    end
  endtask

  // Advance until a frame_start pulse, bounded to two frames.
  task automatic wait_fs(input string tag);
    int n = 0;
    do begin tick(); n++; end while (bus_lz.frame_start !== 1'b1 && n < 2 * FRAME);
    checks++;
    if (bus_lz.frame_start !== 1'b1) begin
      failures++;
      $display("FAIL %s_wait_fs: got no frame_start in %0d cycles want one", tag, n);
    end
  endtask

  task automatic test_digits();
    int n_tens = 0, n_units = 0, n_blank = 0;
    set_in(8'h06, 8'h5B);
    wait_fs("digits");
    for (int i = 0; i < FRAME; i++) begin
      tick();
      checks++;
      if ({bus_lz.seg_out, bus_lz.dig_sel} !== {e_seg_lz, e_dig_lz}) begin
        failures++;
        $display("FAIL digits cyc=%0d: got seg=%h dig=%b want seg=%h dig=%b", i,
                 bus_lz.seg_out, bus_lz.dig_sel, e_seg_lz, e_dig_lz);
      end
      if (bus_lz.seg_out == 8'h06 && bus_lz.dig_sel == 2'b01) n_tens++;
      if (bus_lz.seg_out == 8'h5B && bus_lz.dig_sel == 2'b10) n_units++;
      if (bus_lz.seg_out == 8'h00 && bus_lz.dig_sel == 2'b11) n_blank++;
    end
    checks++;
    if (n_tens != 6 || n_units != 6 || n_blank != 4) begin
      failures++;
      $display("FAIL digits_counts: got tens=%0d units=%0d blank=%0d want 6 6 4",
               n_tens, n_units, n_blank);
    end
  endtask

  task automatic test_lz();
    int lz_tens = 0, nz_zero = 0;
    set_in(8'h3F, 8'h7F);
    wait_fs("lz");
    for (int i = 0; i < FRAME; i++) begin
      tick();
      checks++;
      if ({bus_lz.seg_out, bus_lz.dig_sel, bus_nz.seg_out, bus_nz.dig_sel} !==
          {e_seg_lz, e_dig_lz, e_seg_nz, e_dig_nz}) begin
        failures++;
        $display("FAIL lz cyc=%0d: got lz=%h/%b nz=%h/%b want lz=%h/%b nz=%h/%b", i,
                 bus_lz.seg_out, bus_lz.dig_sel, bus_nz.seg_out, bus_nz.dig_sel,
                 e_seg_lz, e_dig_lz, e_seg_nz, e_dig_nz);
      end
      if (bus_lz.dig_sel == 2'b01) lz_tens++;
      if (bus_nz.seg_out == 8'h3F && bus_nz.dig_sel == 2'b01) nz_zero++;
    end
    checks++;
    if (lz_tens != 0 || nz_zero != 6) begin
      failures++;
      $display("FAIL lz_counts: got lz_tens=%0d nz_zero=%0d want 0 6", lz_tens, nz_zero);
    end
  endtask

  task automatic test_midframe();
    int old_u = 0, new_early = 0, new_u = 0, n = 0;
    set_in(8'h06, 8'h4F);
    wait_fs("mid");
    for (int i = 0; i < 4; i++) tick();
    set_in(8'h06, 8'h66);
    do begin
      tick(); n++;
      if (bus_lz.dig_sel == 2'b10 && bus_lz.seg_out == 8'h4F) old_u++;
      if (bus_lz.seg_out == 8'h66) new_early++;
    end while (bus_lz.frame_start !== 1'b1 && n < 2 * FRAME);
    for (int i = 0; i < FRAME; i++) begin
      tick();
      checks++;
      if ({bus_lz.seg_out, bus_lz.dig_sel} !== {e_seg_lz, e_dig_lz}) begin
        failures++;
        $display("FAIL mid cyc=%0d: got seg=%h dig=%b want seg=%h dig=%b", i,
                 bus_lz.seg_out, bus_lz.dig_sel, e_seg_lz, e_dig_lz);
      end
      if (bus_lz.dig_sel == 2'b10 && bus_lz.seg_out == 8'h66) new_u++;
    end
    checks++;
    if (old_u != 6 || new_early != 0 || new_u != 6) begin
      failures++;
      $display("FAIL mid_counts: got old=%0d early_new=%0d new=%0d want 6 0 6",
               old_u, new_early, new_u);
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    set_in(8'h06, 8'h5B);
    do begin tick(); n++; end while (bus_lz.dig_sel !== 2'b10 && n < 2 * FRAME);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({bus_lz.seg_out, bus_lz.dig_sel, bus_lz.frame_start} !== {8'h00, 2'b11, 1'b0}) begin
      failures++;
      $display("FAIL rst_mid_out: got seg=%h dig=%b fs=%b want seg=00 dig=11 fs=0",
               bus_lz.seg_out, bus_lz.dig_sel, bus_lz.frame_start);
    end
    checks++;
    if (dut_lz.u_tick.cnt_q !== 3'd0 || dut_lz.u_tick.slot_q !== 1'b0 || dut_lz.lat_q !== 16'h0000) begin
      failures++;
      $display("FAIL rst_mid_state: got cnt=%0d slot=%b lat=%h want cnt=0 slot=0 lat=0000",
               dut_lz.u_tick.cnt_q, dut_lz.u_tick.slot_q, dut_lz.lat_q);
    end
    for (int i = 1; i <= 20; i++) begin
      tick();
      checks++;
      if ({bus_lz.seg_out, bus_lz.dig_sel, bus_lz.frame_start} !== {e_seg_lz, e_dig_lz, e_fs}) begin
        failures++;
        $display("FAIL rst_mid_after cyc=%0d: got seg=%h dig=%b fs=%b want seg=%h dig=%b fs=%b", i,
                 bus_lz.seg_out, bus_lz.dig_sel, bus_lz.frame_start, e_seg_lz, e_dig_lz, e_fs);
      end
    end
  endtask

  task automatic test_random();
    int last_fs = -1;
    logic [7:0] a;
    for (int i = 0; i < 1000; i++) begin
      a = ($urandom_range(3) == 0) ? 8'h3F : 8'($urandom);
      set_in(a, 8'($urandom));
      tick();
      checks++;
      if ({bus_lz.seg_out, bus_lz.dig_sel, bus_lz.frame_start, bus_nz.seg_out, bus_nz.dig_sel} !==
          {e_seg_lz, e_dig_lz, e_fs, e_seg_nz, e_dig_nz}) begin
        failures++;
        $display("FAIL rand cyc=%0d: got lz=%h/%b fs=%b nz=%h/%b want lz=%h/%b fs=%b nz=%h/%b", i,
                 bus_lz.seg_out, bus_lz.dig_sel, bus_lz.frame_start, bus_nz.seg_out, bus_nz.dig_sel,
                 e_seg_lz, e_dig_lz, e_fs, e_seg_nz, e_dig_nz);
      end
      checks++;
      if (bus_lz.dig_sel === 2'b00 || bus_nz.dig_sel === 2'b00) begin
        failures++;
        $display("FAIL rand_dig_onehot cyc=%0d: got lz=%b nz=%b want at most one low bit",
                 i, bus_lz.dig_sel, bus_nz.dig_sel);
      end
      if (bus_lz.frame_start === 1'b1) begin
        if (last_fs >= 0) begin
          checks++;
          if (i - last_fs != FRAME) begin
            failures++;
            $display("FAIL rand_fs_period cyc=%0d: got %0d want %0d", i, i - last_fs, FRAME);
          end
        end
        last_fs = i;
      end
    end
  endtask

  initial begin
    set_in(8'h00, 8'h00);
    test_reset();
    test_idle();
    test_digits();
    test_lz();
    test_midframe();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
